// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, selects the next fetch address and flags
// fetch-address exceptions (AdEL) for the instruction handed to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        D_is_ctrl,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instruction,
    output logic        F_BD,
    output logic [4:0]  F_excCode
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_adel;
    logic        w_eret_squash;

    // Exceptions beat the stall; ERET beats a same-cycle redirect because the
    // branch in D belongs to the path being abandoned.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        w_pc_next = r_pc + 32'd4;
        if (req) begin
            w_pc_next = HANDLER_PC;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (eret) begin
            w_pc_next = epc;
        end else if (redirect) begin
            w_pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Bad targets are loaded as-is; the fault surfaces when that PC is fetched.
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);

    // The word after an ERET has no delay-slot semantics, so it becomes a bubble.
    assign w_eret_squash = eret && !stall;

    always_comb begin
        F_Instruction = i_inst_rdata;
        F_excCode     = EXC_NONE;
        if (w_eret_squash) begin
            F_Instruction = 32'h0;
        end else if (w_adel) begin
            F_Instruction = 32'h0;
            F_excCode     = EXC_ADEL;
        end
    end

    assign i_inst_addr = r_pc;
    assign F_PC        = r_pc;
    assign F_BD        = D_is_ctrl;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference PC model feeds a scoreboard of
// expected fetch outputs that is drained at each falling edge.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;
    localparam logic [31:0] RD_KEY     = 32'hA5A5_0F0F;
    localparam logic [31:0] NO_LIT     = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset, req, stall, eret, redirect, D_is_ctrl;
    logic [31:0] epc, target, i_inst_addr, i_inst_rdata;
    logic [31:0] F_PC, F_Instruction;
    logic        F_BD;
    logic [4:0]  F_excCode;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bd;
        logic [4:0]  exc;
        logic [31:0] lit_pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;

    fetch_unit #(
        .RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .TEXT_LO(TEXT_LO), .TEXT_HI(TEXT_HI)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .eret(eret), .epc(epc),
        .redirect(redirect), .target(target), .D_is_ctrl(D_is_ctrl),
        .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .F_PC(F_PC), .F_Instruction(F_Instruction), .F_BD(F_BD), .F_excCode(F_excCode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected fetch outputs, compare at
    // the falling edge, then advance the model PC at the rising edge.
    task automatic cycle(input string tag, input logic c_rst, input logic c_req,
                         input logic c_stall, input logic c_eret, input logic [31:0] c_epc,
                         input logic c_redir, input logic [31:0] c_tgt, input logic c_ctrl,
                         input logic [31:0] lit_pc);
        exp_t        e;
        exp_t        got;
        logic        adel;
        logic [31:0] nxt;
        reset = c_rst; req = c_req; stall = c_stall; eret = c_eret; epc = c_epc;
        redirect = c_redir; target = c_tgt; D_is_ctrl = c_ctrl;
        i_inst_rdata = m_pc ^ RD_KEY;
        adel = (m_pc[1:0] != 2'b00) || (m_pc < TEXT_LO) || (m_pc > TEXT_HI);
        e.tag = tag; e.pc = m_pc; e.bd = c_ctrl; e.lit_pc = lit_pc;
        if (c_eret && !c_stall) begin
            e.inst = 32'h0;            e.exc = 5'd0;
        end else if (adel) begin
            e.inst = 32'h0;            e.exc = 5'd4;
        end else begin
            e.inst = m_pc ^ RD_KEY;    e.exc = 5'd0;
        end
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check32({got.tag, ".pc"},   F_PC,                 got.pc);
        check32({got.tag, ".addr"}, i_inst_addr,          got.pc);
        check32({got.tag, ".inst"}, F_Instruction,        got.inst);
        check32({got.tag, ".bd"},   {31'h0, F_BD},        {31'h0, got.bd});
        check32({got.tag, ".exc"},  {27'h0, F_excCode},   {27'h0, got.exc});
        if (got.lit_pc != NO_LIT) check32({got.tag, ".lit"}, F_PC, got.lit_pc);
        if (c_rst)         nxt = RESET_PC;
        else if (c_req)    nxt = HANDLER_PC;
        else if (c_stall)  nxt = m_pc;
        else if (c_eret)   nxt = c_epc;
        else if (c_redir)  nxt = c_tgt;
        else               nxt = m_pc + 32'd4;
        @(posedge clk);
        m_pc = nxt;
        #1;
    endtask

    task automatic idle(input string tag, input logic ctrl, input logic [31:0] lit_pc);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ctrl, lit_pc);
    endtask

    task automatic jump(input string tag, input logic [31:0] tgt, input logic [31:0] lit_pc);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tgt, 1'b0, lit_pc);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; stall = 1'b0; eret = 1'b0; redirect = 1'b0;
        D_is_ctrl = 1'b0; epc = 32'h0; target = 32'h0; i_inst_rdata = 32'h0;
        m_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;

        // Reset value with reset still asserted, then sequential fetch.
        cycle("rst_hold", 1'b1, 1'b1, 1'b1, 1'b1, 32'h5000, 1'b1, 32'h6000, 1'b0, 32'h3000);
        idle("seq0", 1'b0, 32'h3000);
        idle("seq1", 1'b0, 32'h3004);
        idle("seq2_bd", 1'b1, 32'h3008);
        idle("seq3", 1'b0, 32'h300C);

        // Stall masks a redirect until the stall drops.
        cycle("stall0", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b1, 32'h3010);
        cycle("stall1", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3100, 1'b0, 32'h3010);
        jump("unstall", 32'h3100, 32'h3010);
        jump("at3100", 32'h3020, 32'h3100);

        // Exception request overrides stall.
        cycle("req_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h3020);
        jump("handler", 32'h4200, 32'h4180);

        // ERET beats redirect and squashes its successor.
        cycle("eret", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3044, 1'b1, 32'h5000, 1'b0, 32'h4200);
        jump("epc", 32'h3002, 32'h3044);

        // Misaligned target is loaded unchanged and faults on fetch.
        cycle("adel_mis", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6FFC, 1'b1, 32'h3002);
        idle("text_hi", 1'b0, 32'h6FFC);
        jump("adel_hi", 32'h2FFC, 32'h7000);
        jump("adel_lo", 32'hFFFF_FFFC, 32'h2FFC);
        idle("wrap_top", 1'b0, 32'hFFFF_FFFC);

        // ERET is ignored while stalled; no squash, PC holds.
        cycle("eret_stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 32'h0000_0000);
        // Reset mid-stall/mid-redirect discards the pending next PC.
        cycle("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 32'h0000_0000);
        idle("post_rst", 1'b0, 32'h3000);
        cycle("eret_ok", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3FF0, 1'b0, 32'h0, 1'b1, 32'h3004);
        idle("after_eret", 1'b0, 32'h3FF0);

        check32("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180: exception handler entry.
REQ-003 Parameter TEXT_LO, default 32'h0000_3000: lowest legal fetch address.
REQ-004 Parameter TEXT_HI, default 32'h0000_6FFC: highest legal fetch address.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  exception/interrupt taken this cycle, from CP0.
REQ-008 stall  input  1  hazard stall; hold PC.
REQ-009 eret  input  1  ERET resolved in D this cycle.
REQ-010 epc  input  32  return address for ERET.
REQ-011 redirect  input  1  branch taken or jump in D.
REQ-012 target  input  32  redirect destination.
REQ-013 D_is_ctrl  input  1  instruction in D is a branch/jump.
REQ-014 i_inst_addr  output  32  instruction memory address (= PC).
REQ-015 i_inst_rdata  input  32  instruction memory read data, combinational.
REQ-016 F_PC  output  32  PC of fetched instruction.
REQ-017 F_Instruction  output  32  fetched instruction word.
REQ-018 F_BD  output  1  fetched instruction is in a delay slot.
REQ-019 F_excCode  output  5  fetch exception code, 0 = none.

Function
REQ-020 Single 32-bit PC register; i_inst_addr and F_PC SHALL equal PC combinationally.
REQ-021 Next-PC priority, highest first: reset -> RESET_PC; req -> HANDLER_PC; stall -> hold; eret -> epc; redirect -> target; else PC+4.
REQ-022 req SHALL override stall; eret and redirect SHALL be ignored while stall=1.
REQ-023 eret=1 and redirect=1 together SHALL select epc.
REQ-024 PC+4 SHALL wrap modulo 2^32; no carry out.
REQ-025 AdEL condition: PC[1:0]!=0, or PC<TEXT_LO, or PC>TEXT_HI (unsigned).
REQ-026 On AdEL, F_excCode SHALL be 5'd4 and F_Instruction 32'h0.
REQ-027 Without AdEL, F_excCode SHALL be 0 and F_Instruction SHALL be i_inst_rdata.
REQ-028 When eret=1 and stall=0, F_Instruction SHALL be 32'h0 and F_excCode 0; the ERET successor is squashed, with no delay slot.
REQ-029 F_BD SHALL equal D_is_ctrl, including while stall=1 or on AdEL.
REQ-030 Outputs are combinational from PC and inputs; instruction latency to D is one cycle via the downstream register.
REQ-031 A misaligned or out-of-range redirect target SHALL be loaded unchanged; AdEL is flagged on the following cycle.

Reset
REQ-032 reset=1 at an edge SHALL load PC=RESET_PC regardless of req, stall, eret or redirect.
REQ-033 After reset: F_PC=32'h3000, F_excCode=0, F_Instruction=i_inst_rdata, F_BD=D_is_ctrl.
REQ-034 reset asserted mid-stall or mid-redirect SHALL discard the pending next-PC.

Verification
REQ-035 Reset, then 3 idle cycles -> F_PC sequence 3000, 3004, 3008, 300C.
REQ-036 At PC=3010, stall=1 for 2 cycles with redirect=1, target=3100 -> PC holds 3010 both cycles; then stall=0, redirect=1 -> PC=3100.
REQ-037 At PC=3020, stall=1 and req=1 at the same edge -> PC=4180 at the next edge.
REQ-038 At PC=4200, eret=1, epc=3044, redirect=1, target=5000 -> F_Instruction=0 that cycle; next PC=3044.
REQ-039 redirect to target=3002 -> next cycle F_excCode=4, F_Instruction=0; PC=6FFC then +4 -> F_excCode=4 at 7000.
REQ-040 D_is_ctrl=1 at PC=3008 -> F_BD=1; D_is_ctrl=0 -> F_BD=0.
